pc_gen_multi: RTL and testbench
===============================

Name: pc_gen_multi

Overview:
- Parametrised fetch-PC generator; next generation of the front-end PC register.
- Supports N-wide fetch, a configurable number of prioritised redirect channels, and a valid/ready fetch-request handshake with one outstanding request.
- Kills the stale response when a redirect lands mid-fetch.
- Sits between the back-end redirect sources (exception, mispredict, flush, decode branch/jump) and the I-cache request port, ahead of the instruction FIFO.

Parameters:
- FETCH_WIDTH, 2: maximum instructions per fetch request (power of two, 1..8).
- NUM_REDIRECT, 6: number of redirect channels; channel 0 has highest priority.
- RESET_PC, 32'hbfc00000: PC loaded on reset.
- CNT_W, $clog2(FETCH_WIDTH+1): width of the instruction-count fields.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- redir_valid  in  NUM_REDIRECT  per-channel redirect request.
- redir_target  in  NUM_REDIRECT*32  per-channel target; channel i occupies bits [32*i+31:32*i].
- fifo_full  in  1  downstream instruction FIFO cannot accept; blocks issue.
- req_valid  out  1  fetch request valid.
- req_ready  in  1  I-cache accepts the request.
- req_pc  out  32  fetch address (equals pc_curr).
- req_max  out  CNT_W  maximum instructions the cache may return for this request.
- resp_valid  in  1  fetch response valid (single cycle).
- resp_count  in  CNT_W  instructions returned; 0 means none usable.
- drop_resp  out  1  combinational; the current response is stale and must be discarded by the FIFO.
- pc_curr  out  32  registered current fetch PC.
- pc_next  out  32  combinational next PC, used for I-cache index lookahead.
- pc_misalign  out  1  pc_curr[1:0] != 0.
- busy  out  1  state != S_ISSUE.

Behaviour:
- Reset: pc_curr = RESET_PC, state S_ISSUE, req_valid = 0, drop_resp = 0, busy = 0. While rst is high, pc_next = RESET_PC.
- Redirect select: any_redir = OR of redir_valid. sel_target = target of the lowest-index valid channel.
- States: S_ISSUE (free), S_WAIT (request accepted, awaiting response), S_KILL (response outstanding but stale).
- req_valid = (state == S_ISSUE) & ~fifo_full & ~any_redir & ~pc_misalign.
- S_ISSUE:
  - any_redir: pc_next = sel_target, stay in S_ISSUE.
  - else req_valid & req_ready: go to S_WAIT, pc unchanged.
  - else hold.
- S_WAIT:
  - any_redir (with or without resp_valid in the same cycle): pc_next = sel_target. drop_resp = resp_valid. Next state = resp_valid ? S_ISSUE : S_KILL.
  - resp_valid without redirect: pc_next = pc_curr + 4*min(resp_count, req_max_latched); go to S_ISSUE. resp_count = 0 re-fetches the same PC.
- S_KILL:
  - Any further redirect: pc_next = sel_target.
  - resp_valid: drop_resp = 1, go to S_ISSUE.
- pc_next = pc_curr in all other cases. Addition wraps modulo 2^32 with no overflow flag.
- req_max is latched at the handshake and used to clip the response count.
- Misaligned PC (from a redirect):
  - No request is issued and pc_misalign = 1; the PC is held.
  - The redirect that clears it is the exception redirect, supplied by the back end.
- fifo_full only blocks issue. An outstanding response is still accepted; the FIFO keeps skid space for one response.
- Simultaneous redirects: the lowest channel index wins, the others are ignored that cycle.
- rst asserted mid-fetch: returns to S_ISSUE at RESET_PC. The outstanding response after reset is not killed; the cache is reset with the same rst.

Optional Feature:
- Macro: PC_GEN_LINE_CLIP_EN.
- Defined: req_max = FETCH_WIDTH - pc_curr[$clog2(FETCH_WIDTH)+1:2], so a fetch never crosses a FETCH_WIDTH*4-byte aligned block.
- Undefined: req_max = FETCH_WIDTH constantly. The cache handles block crossing.

Decomposition:
- Shared package front_pkg holds:
  - pc_state_e enum {S_ISSUE, S_WAIT, S_KILL};
  - RESET_PC_DEFAULT;
  - INST_BYTES = 4.
- One sub-module, redirect_arbiter: fixed-priority one-hot select over NUM_REDIRECT channels, producing any_redir and sel_target.

Test Plan:
1. Reset, then req_ready=1 and resp_valid with resp_count=2 each round trip (FETCH_WIDTH=2) -> req_pc sequence bfc00000, bfc00008, bfc00010; drop_resp stays 0.
2. Channels 1 and 4 redirect in the same cycle in S_ISSUE, targets 80000100 and 80000200 -> pc_curr = 80000100; req_valid is 0 that cycle.
3. Redirect to 80001000 in S_WAIT, resp_valid arrives two cycles later -> state goes to S_KILL, drop_resp = 1 on that response, the next req_pc is 80001000.
4. Redirect and resp_valid in the same S_WAIT cycle -> drop_resp = 1, pc_curr = target, state S_ISSUE.
5. fifo_full=1 in S_ISSUE for 5 cycles -> req_valid = 0 and pc held; on deassertion, a request is issued the next cycle with the same PC.
6. With PC_GEN_LINE_CLIP_EN, FETCH_WIDTH=4, pc=80000008 -> req_max = 2; resp_count=4 advances pc to 80000010. Without the macro -> req_max = 4 and pc advances to 80000018.

Source files
------------

// File: rtl/front_pkg.sv
// rtl/front_pkg.sv - shared front-end types and constants for the fetch-PC generator
package front_pkg;

    typedef enum logic [1:0] {
        S_ISSUE = 2'd0,
        S_WAIT  = 2'd1,
        S_KILL  = 2'd2
    } pc_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hbfc00000;
    localparam int unsigned INST_BYTES       = 4;

endpackage

// File: rtl/redirect_arbiter.sv
// rtl/redirect_arbiter.sv - fixed-priority one-hot redirect select, channel 0 highest
import front_pkg::*;

module redirect_arbiter #(
    parameter int NUM_REDIRECT = 6
) (
    input  logic [NUM_REDIRECT-1:0]    redir_valid,
    input  logic [NUM_REDIRECT*32-1:0] redir_target,
    output logic                       any_redir,
    output logic [31:0]                sel_target
);

    logic [NUM_REDIRECT-1:0] grant;

    // Isolate the lowest set request bit to form a one-hot grant.
    assign grant     = redir_valid & ~(redir_valid - NUM_REDIRECT'(1));
    assign any_redir = |redir_valid;

    // AND-OR mux of the granted channel's target.
    always_comb begin
        sel_target = '0;
        for (int i = 0; i < NUM_REDIRECT; i++) begin
            sel_target = sel_target | ({32{grant[i]}} & redir_target[32*i +: 32]);
        end
    end

endmodule

// File: rtl/pc_gen_multi.sv
// rtl/pc_gen_multi.sv - N-wide fetch-PC generator with redirects and stale-response kill (PC_GEN_LINE_CLIP_EN clips fetches at block boundaries)
import front_pkg::*;

module pc_gen_multi #(
    parameter int          FETCH_WIDTH  = 2,
    parameter int          NUM_REDIRECT = 6,
    parameter logic [31:0] RESET_PC     = RESET_PC_DEFAULT,
    parameter int          CNT_W        = $clog2(FETCH_WIDTH+1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REDIRECT-1:0]    redir_valid,
    input  logic [NUM_REDIRECT*32-1:0] redir_target,
    input  logic                       fifo_full,
    output logic                       req_valid,
    input  logic                       req_ready,
    output logic [31:0]                req_pc,
    output logic [CNT_W-1:0]           req_max,
    input  logic                       resp_valid,
    input  logic [CNT_W-1:0]           resp_count,
    output logic                       drop_resp,
    output logic [31:0]                pc_curr,
    output logic [31:0]                pc_next,
    output logic                       pc_misalign,
    output logic                       busy
);

    localparam int OFF_W = $clog2(FETCH_WIDTH);

    pc_state_e        state;
    pc_state_e        state_nxt;
    logic [31:0]      pc_q;
    logic [CNT_W-1:0] max_q;
    logic             any_redir;
    logic [31:0]      sel_target;
    logic [CNT_W-1:0] eff_cnt;
    logic [31:0]      advance;

    redirect_arbiter #(
        .NUM_REDIRECT (NUM_REDIRECT)
    ) u_arb (
        .redir_valid  (redir_valid),
        .redir_target (redir_target),
        .any_redir    (any_redir),
        .sel_target   (sel_target)
    );

`ifdef PC_GEN_LINE_CLIP_EN
    // Limit the request so it stops at the end of the aligned fetch block.
    generate
        if (OFF_W > 0) begin : g_clip
            assign req_max = CNT_W'(FETCH_WIDTH) - CNT_W'(pc_q[OFF_W+1:2]);
        end else begin : g_single
            assign req_max = CNT_W'(FETCH_WIDTH);
        end
    endgenerate
`else
    assign req_max = CNT_W'(FETCH_WIDTH);
`endif

    assign pc_curr     = pc_q;
    assign req_pc      = pc_q;
    assign pc_misalign = (pc_q[1:0] != 2'b00);
    assign busy        = (state != S_ISSUE);
    assign req_valid   = ~rst & (state == S_ISSUE) & ~fifo_full & ~any_redir & ~pc_misalign;

    // The cache may return more than it was allowed; clip to the latched maximum.
    assign eff_cnt = (resp_count < max_q) ? resp_count : max_q;
    assign advance = 32'(eff_cnt) * 32'(INST_BYTES);

    // Next-state, next-PC and response-kill decode.
    always_comb begin
        state_nxt = state;
        pc_next   = pc_q;
        drop_resp = 1'b0;
        unique case (state)
            S_ISSUE: begin
                if (any_redir) begin
                    pc_next = sel_target;
                end else if (req_valid && req_ready) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (any_redir) begin
                    pc_next   = sel_target;
                    drop_resp = resp_valid;
                    state_nxt = resp_valid ? S_ISSUE : S_KILL;
                end else if (resp_valid) begin
                    pc_next   = pc_q + advance;
                    state_nxt = S_ISSUE;
                end
            end
            S_KILL: begin
                if (any_redir) begin
                    pc_next = sel_target;
                end
                if (resp_valid) begin
                    drop_resp = 1'b1;
                    state_nxt = S_ISSUE;
                end
            end
            default: begin
                state_nxt = S_ISSUE;
            end
        endcase
        // The cache shares this reset, so nothing is killed while it is held.
        if (rst) begin
            pc_next   = RESET_PC;
            drop_resp = 1'b0;
            state_nxt = S_ISSUE;
        end
    end

    // State, PC and the request maximum captured at the handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_ISSUE;
            pc_q  <= RESET_PC;
            max_q <= CNT_W'(FETCH_WIDTH);
        end else begin
            state <= state_nxt;
            pc_q  <= pc_next;
            if (state == S_ISSUE && req_valid && req_ready) begin
                max_q <= req_max;
            end
        end
    end

endmodule

// File: tb/tb_pc_gen_multi.sv
// tb/tb_pc_gen_multi.sv - self-checking bench for pc_gen_multi against a transaction-level model
module tb_pc_gen_multi;

    localparam int          FW    = 4;
    localparam int          NR    = 6;
    localparam int          CW    = $clog2(FW+1);
    localparam logic [31:0] RST_PC = 32'hbfc00000;
`ifdef PC_GEN_LINE_CLIP_EN
    localparam bit CLIP = 1'b1;
`else
    localparam bit CLIP = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic [NR-1:0]     redir_valid;
    logic [NR*32-1:0]  redir_target;
    logic              fifo_full;
    logic              req_valid;
    logic              req_ready;
    logic [31:0]       req_pc;
    logic [CW-1:0]     req_max;
    logic              resp_valid;
    logic [CW-1:0]     resp_count;
    logic              drop_resp;
    logic [31:0]       pc_curr;
    logic [31:0]       pc_next;
    logic              pc_misalign;
    logic              busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: current PC, whether a request is in flight, whether it went stale, its limit.
    logic [31:0] m_pc    = RST_PC;
    logic        m_out   = 1'b0;
    logic        m_stale = 1'b0;
    int          m_max   = FW;

    pc_gen_multi #(
        .FETCH_WIDTH  (FW),
        .NUM_REDIRECT (NR),
        .RESET_PC     (RST_PC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .redir_valid  (redir_valid),
        .redir_target (redir_target),
        .fifo_full    (fifo_full),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_pc       (req_pc),
        .req_max      (req_max),
        .resp_valid   (resp_valid),
        .resp_count   (resp_count),
        .drop_resp    (drop_resp),
        .pc_curr      (pc_curr),
        .pc_next      (pc_next),
        .pc_misalign  (pc_misalign),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_target();
        for (int i = 0; i < NR; i++)
            if (redir_valid[i]) return redir_target[32*i +: 32];
        return 32'h0;
    endfunction

    function automatic int ref_max(input logic [31:0] pc);
        if (CLIP) return FW - int'((pc >> 2) % FW);
        return FW;
    endfunction

    function automatic logic ref_req_valid();
        return !rst && !m_out && !fifo_full && (redir_valid == 0) && (m_pc[1:0] == 2'b00);
    endfunction

    function automatic logic ref_drop();
        return !rst && m_out && resp_valid && (m_stale || (redir_valid != 0));
    endfunction

    function automatic logic [31:0] ref_pc_next();
        int n;
        if (rst) return RST_PC;
        if (redir_valid != 0) return ref_target();
        if (m_out && !m_stale && resp_valid) begin
            n = (int'(resp_count) < m_max) ? int'(resp_count) : m_max;
            return m_pc + 32'(4 * n);
        end
        return m_pc;
    endfunction

    task automatic clear_inputs();
        redir_valid  = '0;
        redir_target = '0;
        fifo_full    = 1'b0;
        req_ready    = 1'b0;
        resp_valid   = 1'b0;
        resp_count   = '0;
    endtask

    task automatic set_redir(input int ch, input logic [31:0] tgt);
        redir_valid[ch]          = 1'b1;
        redir_target[32*ch +: 32] = tgt;
    endtask

    // Advance one clock, moving the model with the inputs present before the edge.
    task automatic tick();
        logic [31:0] npc;
        logic        nout;
        logic        nst;
        int          nmax;
        npc  = ref_pc_next();
        nout = m_out;
        nst  = m_stale;
        nmax = m_max;
        if (rst) begin
            nout = 1'b0;
            nst  = 1'b0;
        end else if (m_out) begin
            if (resp_valid) begin
                nout = 1'b0;
                nst  = 1'b0;
            end else if (redir_valid != 0) begin
                nst = 1'b1;
            end
        end else if (ref_req_valid() && req_ready) begin
            nout = 1'b1;
            nst  = 1'b0;
            nmax = ref_max(m_pc);
        end
        @(posedge clk);
        m_pc    = npc;
        m_out   = nout;
        m_stale = nst;
        m_max   = nmax;
        @(negedge clk);
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        @(negedge clk);
        set_redir(0, 32'h12345678);
        resp_valid = 1'b1;
        #1;
        n_checks++; if (pc_next !== RST_PC) begin n_fail++; $display("FAIL reset_pc_next: got %h want %h", pc_next, RST_PC); end
        n_checks++; if (req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid: got %b want 0", req_valid); end
        n_checks++; if (drop_resp !== 1'b0) begin n_fail++; $display("FAIL reset_drop: got %b want 0", drop_resp); end
        tick();
        tick();
        rst = 1'b0;
        clear_inputs();
        #1;
        n_checks++; if (pc_curr !== RST_PC) begin n_fail++; $display("FAIL reset_pc_curr: got %h want %h", pc_curr, RST_PC); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pcs [3];
        exp_pcs = '{32'hbfc00000, 32'hbfc00008, 32'hbfc00010};
        for (int i = 0; i < 3; i++) begin
            clear_inputs();
            req_ready = 1'b1;
            #1;
            n_checks++; if (req_valid !== 1'b1) begin n_fail++; $display("FAIL seq_req_valid[%0d]: got %b want 1", i, req_valid); end
            n_checks++; if (req_pc !== exp_pcs[i]) begin n_fail++; $display("FAIL seq_req_pc[%0d]: got %h want %h", i, req_pc, exp_pcs[i]); end
            tick();
            clear_inputs();
            resp_valid = 1'b1;
            resp_count = CW'(2);
            #1;
            n_checks++; if (drop_resp !== 1'b0) begin n_fail++; $display("FAIL seq_drop[%0d]: got %b want 0", i, drop_resp); end
            n_checks++; if (pc_next !== exp_pcs[i] + 32'd8) begin n_fail++; $display("FAIL seq_pc_next[%0d]: got %h want %h", i, pc_next, exp_pcs[i] + 32'd8); end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_priority();
        clear_inputs();
        set_redir(1, 32'h80000100);
        set_redir(4, 32'h80000200);
        req_ready = 1'b1;
        #1;
        n_checks++; if (req_valid !== 1'b0) begin n_fail++; $display("FAIL prio_req_valid: got %b want 0", req_valid); end
        n_checks++; if (pc_next !== 32'h80000100) begin n_fail++; $display("FAIL prio_pc_next: got %h want 80000100", pc_next); end
        tick();
        clear_inputs();
        #1;
        n_checks++; if (pc_curr !== 32'h80000100) begin n_fail++; $display("FAIL prio_pc_curr: got %h want 80000100", pc_curr); end
    endtask

    task automatic test_kill();
        clear_inputs();
        req_ready = 1'b1;
        #1;
        tick();
        clear_inputs();
        set_redir(0, 32'h80001000);
        #1;
        n_checks++; if (pc_next !== 32'h80001000) begin n_fail++; $display("FAIL kill_pc_next: got %h want 80001000", pc_next); end
        tick();
        clear_inputs();
        #1;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL kill_busy: got %b want 1", busy); end
        tick();
        resp_valid = 1'b1;
        resp_count = CW'(2);
        #1;
        n_checks++; if (drop_resp !== 1'b1) begin n_fail++; $display("FAIL kill_drop: got %b want 1", drop_resp); end
        n_checks++; if (pc_next !== 32'h80001000) begin n_fail++; $display("FAIL kill_pc_hold: got %h want 80001000", pc_next); end
        tick();
        clear_inputs();
        req_ready = 1'b1;
        #1;
        n_checks++; if (req_valid !== 1'b1 || req_pc !== 32'h80001000) begin n_fail++; $display("FAIL kill_reissue: got valid=%b pc=%h want valid=1 pc=80001000", req_valid, req_pc); end
        tick();
        clear_inputs();
        resp_valid = 1'b1;
        resp_count = CW'(1);
        tick();
        clear_inputs();
    endtask

    task automatic test_redir_with_resp();
        clear_inputs();
        req_ready = 1'b1;
        #1;
        tick();
        clear_inputs();
        set_redir(2, 32'h80002000);
        resp_valid = 1'b1;
        resp_count = CW'(2);
        #1;
        n_checks++; if (drop_resp !== 1'b1) begin n_fail++; $display("FAIL same_cycle_drop: got %b want 1", drop_resp); end
        tick();
        clear_inputs();
        #1;
        n_checks++; if (pc_curr !== 32'h80002000) begin n_fail++; $display("FAIL same_cycle_pc: got %h want 80002000", pc_curr); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL same_cycle_busy: got %b want 0", busy); end
    endtask

    task automatic test_fifo_full();
        clear_inputs();
        fifo_full = 1'b1;
        req_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++; if (req_valid !== 1'b0 || pc_curr !== 32'h80002000) begin n_fail++; $display("FAIL full_hold[%0d]: got valid=%b pc=%h want valid=0 pc=80002000", i, req_valid, pc_curr); end
            tick();
        end
        fifo_full = 1'b0;
        #1;
        n_checks++; if (req_valid !== 1'b1 || req_pc !== 32'h80002000) begin n_fail++; $display("FAIL full_release: got valid=%b pc=%h want valid=1 pc=80002000", req_valid, req_pc); end
        tick();
        clear_inputs();
        fifo_full  = 1'b1;
        resp_valid = 1'b1;
        resp_count = CW'(0);
        #1;
        n_checks++; if (pc_next !== 32'h80002000 || drop_resp !== 1'b0) begin n_fail++; $display("FAIL zero_count: got pc=%h drop=%b want pc=80002000 drop=0", pc_next, drop_resp); end
        tick();
        clear_inputs();
        req_ready = 1'b1;
        #1;
        tick();
        clear_inputs();
        fifo_full  = 1'b1;
        resp_valid = 1'b1;
        resp_count = CW'(3);
        #1;
        n_checks++; if (pc_next !== 32'h8000200c) begin n_fail++; $display("FAIL full_accept_resp: got %h want 8000200c", pc_next); end
        tick();
        clear_inputs();
    endtask

    task automatic test_clip();
        logic [CW-1:0] exp_max;
        logic [31:0]   exp_pc;
        exp_max = CLIP ? CW'(2) : CW'(4);
        exp_pc  = CLIP ? 32'h80000010 : 32'h80000018;
        clear_inputs();
        set_redir(3, 32'h80000008);
        tick();
        clear_inputs();
        req_ready = 1'b1;
        #1;
        n_checks++; if (req_max !== exp_max) begin n_fail++; $display("FAIL clip_req_max: got %0d want %0d", req_max, exp_max); end
        tick();
        clear_inputs();
        resp_valid = 1'b1;
        resp_count = CW'(4);
        tick();
        clear_inputs();
        #1;
        n_checks++; if (pc_curr !== exp_pc) begin n_fail++; $display("FAIL clip_advance: got %h want %h", pc_curr, exp_pc); end
    endtask

    task automatic test_misalign();
        clear_inputs();
        set_redir(5, 32'h80000102);
        tick();
        clear_inputs();
        req_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++; if (pc_misalign !== 1'b1 || req_valid !== 1'b0 || pc_curr !== 32'h80000102) begin n_fail++; $display("FAIL misalign_hold[%0d]: got mis=%b valid=%b pc=%h want mis=1 valid=0 pc=80000102", i, pc_misalign, req_valid, pc_curr); end
            tick();
        end
        set_redir(0, 32'h80000200);
        tick();
        clear_inputs();
        req_ready = 1'b1;
        #1;
        n_checks++; if (pc_misalign !== 1'b0 || req_valid !== 1'b1) begin n_fail++; $display("FAIL misalign_clear: got mis=%b valid=%b want mis=0 valid=1", pc_misalign, req_valid); end
        clear_inputs();
    endtask

    task automatic test_wrap();
        logic [31:0] exp_pc;
        exp_pc = CLIP ? 32'h00000000 : 32'h00000008;
        clear_inputs();
        set_redir(1, 32'hfffffff8);
        tick();
        clear_inputs();
        req_ready = 1'b1;
        #1;
        tick();
        clear_inputs();
        resp_valid = 1'b1;
        resp_count = CW'(4);
        tick();
        clear_inputs();
        #1;
        n_checks++; if (pc_curr !== exp_pc) begin n_fail++; $display("FAIL wrap_pc: got %h want %h", pc_curr, exp_pc); end
    endtask

    task automatic test_reset_midfetch();
        clear_inputs();
        req_ready = 1'b1;
        #1;
        tick();
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        resp_valid = 1'b1;
        resp_count = CW'(2);
        #1;
        n_checks++; if (pc_curr !== RST_PC || busy !== 1'b0) begin n_fail++; $display("FAIL midfetch_reset: got pc=%h busy=%b want pc=%h busy=0", pc_curr, busy, RST_PC); end
        n_checks++; if (drop_resp !== 1'b0 || pc_next !== RST_PC) begin n_fail++; $display("FAIL midfetch_resp: got drop=%b pc_next=%h want drop=0 pc_next=%h", drop_resp, pc_next, RST_PC); end
        tick();
        clear_inputs();
    endtask

    task automatic test_random();
        logic [CW-1:0] emax;
        for (int c = 0; c < 400; c++) begin
            redir_valid = ($urandom_range(0, 7) == 0) ? NR'($urandom) : '0;
            for (int i = 0; i < NR; i++) begin
                redir_target[32*i +: 32] = {$urandom_range(0, 32'h3fffffff), 2'b00};
                if ($urandom_range(0, 15) == 0) redir_target[32*i +: 2] = 2'($urandom);
            end
            fifo_full  = ($urandom_range(0, 3) == 0);
            req_ready  = $urandom_range(0, 1) == 1;
            resp_valid = ($urandom_range(0, 2) == 0);
            resp_count = CW'($urandom_range(0, 7));
            rst        = ($urandom_range(0, 96) == 0);
            #1;
            emax = CW'(ref_max(m_pc));
            n_checks++; if (req_valid !== ref_req_valid()) begin n_fail++; $display("FAIL rnd_req_valid[%0d]: got %b want %b", c, req_valid, ref_req_valid()); end
            n_checks++; if (drop_resp !== ref_drop()) begin n_fail++; $display("FAIL rnd_drop[%0d]: got %b want %b", c, drop_resp, ref_drop()); end
            n_checks++; if (pc_next !== ref_pc_next()) begin n_fail++; $display("FAIL rnd_pc_next[%0d]: got %h want %h", c, pc_next, ref_pc_next()); end
            n_checks++; if (pc_curr !== m_pc || req_pc !== m_pc) begin n_fail++; $display("FAIL rnd_pc_curr[%0d]: got %h/%h want %h", c, pc_curr, req_pc, m_pc); end
            n_checks++; if (busy !== m_out) begin n_fail++; $display("FAIL rnd_busy[%0d]: got %b want %b", c, busy, m_out); end
            n_checks++; if (pc_misalign !== (m_pc[1:0] != 2'b00)) begin n_fail++; $display("FAIL rnd_misalign[%0d]: got %b want %b", c, pc_misalign, m_pc[1:0] != 2'b00); end
            n_checks++; if (req_max !== emax) begin n_fail++; $display("FAIL rnd_req_max[%0d]: got %0d want %0d", c, req_max, emax); end
            tick();
        end
        rst = 1'b0;
        clear_inputs();
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_sequential();
        test_priority();
        test_kill();
        test_redir_with_resp();
        test_fifo_full();
        test_clip();
        test_misalign();
        test_wrap();
        test_reset_midfetch();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
